// File: rtl/layer1_weight_loader_pkg.sv
// Shared definitions for the Layer 1 weight path: default sizes, boolean
// constants and the loader state encoding.
package layer1_weight_loader_pkg;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   // Default geometry of the Layer 1 weight memory
   localparam int RELU_NODES         = 16;
   localparam int LAYER_1_BIT_WIDTH  = 16;
   localparam int LAYER_1_INPUT_ROWS = 784;

   // Row index width is fixed by the storage port (up to 1024 rows)
   localparam int ROW_INDEX_WIDTH = 10;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_WRITE   = 2'd2,
      ST_DONE    = 2'd3
   } loader_state_t;

endpackage

// File: rtl/layer1_weight_loader.sv
// Serial-to-row packer for the Layer 1 weight storage. Collects NODES weights
// per row over a valid/ready handshake, strobes each full row into storage
// and pulses done after INPUT_ROWS rows.
module layer1_weight_loader
   import layer1_weight_loader_pkg::*;
#(
   parameter int NODES      = RELU_NODES,
   parameter int BIT_WIDTH  = LAYER_1_BIT_WIDTH,
   parameter int INPUT_ROWS = LAYER_1_INPUT_ROWS
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic [BIT_WIDTH-1:0]         weightIn,
   input  logic                         weightValid,
   output logic                         weightReady,
   output logic                         writeEnable,
   output logic [ROW_INDEX_WIDTH-1:0]   NodeSelect,
   output logic [NODES*BIT_WIDTH-1:0]   writeIn,
   output logic                         busy,
   output logic                         done
);

   localparam int SLOT_WIDTH = (NODES > 1) ? $clog2(NODES) : 1;
   localparam logic [SLOT_WIDTH-1:0]      LAST_SLOT = SLOT_WIDTH'(NODES - 1);
   localparam logic [ROW_INDEX_WIDTH-1:0] LAST_ROW  = ROW_INDEX_WIDTH'(INPUT_ROWS - 1);

   loader_state_t         state_r;
   logic [SLOT_WIDTH-1:0] slot_r;
   logic                  accept_s;

   // A weight is consumed only while ready is asserted (i.e. in COLLECT)
   always_comb begin
      accept_s = weightValid && weightReady;
   end

   // Load sequencer: state, slot/row counters, row register and all
   // outputs are updated together so every output is a flop
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         slot_r      <= '0;
         NodeSelect  <= '0;
         writeIn     <= '0;
         weightReady <= FALSE;
         writeEnable <= FALSE;
         busy        <= FALSE;
         done        <= FALSE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  state_r     <= ST_COLLECT;
                  slot_r      <= '0;
                  NodeSelect  <= '0;
                  weightReady <= TRUE;
                  busy        <= TRUE;
               end else begin
                  weightReady <= FALSE;
                  busy        <= FALSE;
               end
               writeEnable <= FALSE;
               done        <= FALSE;
            end

            ST_COLLECT: begin
               if (accept_s) begin
                  // Slot k lands in slice k; earlier slots keep their values
                  writeIn[int'(slot_r)*BIT_WIDTH +: BIT_WIDTH] <= weightIn;
                  if (slot_r == LAST_SLOT) begin
                     state_r     <= ST_WRITE;
                     slot_r      <= '0;
                     weightReady <= FALSE;
                     writeEnable <= TRUE;
                  end else begin
                     slot_r <= slot_r + SLOT_WIDTH'(1);
                  end
               end else begin
                  slot_r <= slot_r;
               end
            end

            ST_WRITE: begin
               writeEnable <= FALSE;
               if (NodeSelect == LAST_ROW) begin
                  state_r <= ST_DONE;
                  done    <= TRUE;
               end else begin
                  state_r     <= ST_COLLECT;
                  NodeSelect  <= NodeSelect + ROW_INDEX_WIDTH'(1);
                  weightReady <= TRUE;
               end
            end

            ST_DONE: begin
               state_r    <= ST_IDLE;
               NodeSelect <= '0;
               done       <= FALSE;
               busy       <= FALSE;
            end

            default: begin
               state_r     <= ST_IDLE;
               slot_r      <= '0;
               NodeSelect  <= '0;
               weightReady <= FALSE;
               writeEnable <= FALSE;
               busy        <= FALSE;
               done        <= FALSE;
            end
         endcase
      end
   end

endmodule
